// File: rtl/aes_pkg.sv
// Shared AES MixColumns types, GF(2^8) helpers and the engine FSM encoding.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;
    localparam int         NB       = 4;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  col_t;
    typedef logic [7:0]   byte_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_state_t;

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic byte_t xtime(input byte_t b);
        return b[7] ? ({b[6:0], 1'b0} ^ AES_POLY) : {b[6:0], 1'b0};
    endfunction

    function automatic byte_t gf_mul2(input byte_t b);
        return xtime(b);
    endfunction

    function automatic byte_t gf_mul4(input byte_t b);
        return xtime(xtime(b));
    endfunction

    function automatic byte_t gf_mul8(input byte_t b);
        return xtime(xtime(xtime(b)));
    endfunction

    // Column 0 occupies the MSBs of the state (FIPS-197 byte order).
    function automatic col_t get_col(input state_t s, input logic [1:0] idx);
        return s[127 - 32 * int'(idx) -: 32];
    endfunction

    function automatic state_t set_col(input state_t s, input logic [1:0] idx, input col_t c);
        state_t r;
        r = s;
        r[127 - 32 * int'(idx) -: 32] = c;
        return r;
    endfunction

endpackage

// File: rtl/mix_columns_engine_core.sv
// Combinational single-column MixColumns / InvMixColumns.
module mix_column_core
    import aes_pkg::*;
(
    input  logic inv,
    input  col_t col_in,
    output col_t col_out
);

    byte_t a0, a1, a2, a3;
    byte_t f0, f1, f2, f3;
    byte_t p, q, t, p4, q4, t8;

    // The inverse matrix differs from the forward one by 8*(a0^a1^a2^a3)
    // plus 4*(a0^a2) on even rows or 4*(a1^a3) on odd rows.
    always_comb begin
        a0 = col_in[31:24];
        a1 = col_in[23:16];
        a2 = col_in[15:8];
        a3 = col_in[7:0];

        p  = a0 ^ a2;
        q  = a1 ^ a3;
        t  = p ^ q;

        f0 = a0 ^ t ^ gf_mul2(a0 ^ a1);
        f1 = a1 ^ t ^ gf_mul2(a1 ^ a2);
        f2 = a2 ^ t ^ gf_mul2(a2 ^ a3);
        f3 = a3 ^ t ^ gf_mul2(a3 ^ a0);

        p4 = gf_mul4(p);
        q4 = gf_mul4(q);
        t8 = gf_mul8(t);

        col_out = {f0, f1, f2, f3};
        if (inv) begin
            col_out = {f0 ^ t8 ^ p4, f1 ^ t8 ^ q4, f2 ^ t8 ^ p4, f3 ^ t8 ^ q4};
        end
    end

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative AES (Inv)MixColumns over a 128-bit state with valid/ready on both sides.
module mix_columns_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYC = 1,
    parameter int NUM_COLS     = NB
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int         GROUPS   = NUM_COLS / COLS_PER_CYC;
    localparam logic [1:0] LAST_GRP = 2'(GROUPS - 1);

    if (!(COLS_PER_CYC == 1 || COLS_PER_CYC == 2 || COLS_PER_CYC == 4) || NUM_COLS != NB) begin : g_bad_param
        $error("mix_columns_engine: COLS_PER_CYC must be 1, 2 or 4 and NUM_COLS must be 4");
    end

    fsm_state_t state_q, state_d;
    state_t     work_q, work_d, result_q;
    logic [1:0] cnt_q;
    logic       inv_q;

    logic [1:0] col_idx [COLS_PER_CYC];
    col_t       col_res [COLS_PER_CYC];

    for (genvar g = 0; g < COLS_PER_CYC; g++) begin : g_core
        assign col_idx[g] = 2'(int'(cnt_q) * COLS_PER_CYC + g);

        mix_column_core u_core (
            .inv    (inv_q),
            .col_in (get_col(work_q, col_idx[g])),
            .col_out(col_res[g])
        );
    end

    always_comb begin
        work_d = work_q;
        for (int g = 0; g < COLS_PER_CYC; g++) begin
            work_d = set_col(work_d, col_idx[g], col_res[g]);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)            state_d = RUN;
            RUN:     if (cnt_q == LAST_GRP)   state_d = DONE;
            DONE:    if (out_ready)           state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The result register only updates on the final group, so the previous
    // result stays visible on out_state while the next state is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            inv_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q <= in_state;
                        inv_q  <= in_inv;
                        cnt_q  <= '0;
                    end
                end
                RUN: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q + 2'd1;
                    if (cnt_q == LAST_GRP) begin
                        result_q <= work_d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_state = result_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: one instance per legal COLS_PER_CYC, checked against a matrix model.
module tb_mix_columns_engine;

    localparam logic [127:0] VEC_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] VEC_FWD = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         in_inv    [3];
    logic [127:0] in_state  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_state [3];
    logic         busy      [3];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [127:0] exp_r   [3];
    bit           pend    [3];
    int           acc_cyc [3];
    bit           prev_ov [3];

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        mix_columns_engine #(.COLS_PER_CYC(1 << i)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[i]),
            .in_ready (in_ready[i]),
            .in_inv   (in_inv[i]),
            .in_state (in_state[i]),
            .out_valid(out_valid[i]),
            .out_ready(out_ready[i]),
            .out_state(out_state[i]),
            .busy     (busy[i])
        );
    end

    // Plain shift-and-add field multiply; the model uses full matrix products.
    function automatic logic [7:0] gf_mult(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] model_mix(input logic [127:0] s, input logic inv);
        logic [7:0]   base [4];
        logic [7:0]   a    [4];
        logic [7:0]   acc;
        logic [127:0] r;
        r = '0;
        if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc ^= gf_mult(base[(k - row + 4) % 4], a[k]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL %s: wait expired without the expected handshake", name);
    endtask

    // Records what each instance must return, taken at its accept edge.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                pend[i] = 1'b0;
            end else begin
                if (out_valid[i] && out_ready[i]) pend[i] = 1'b0;
                if (in_valid[i] && in_ready[i]) begin
                    exp_r[i]   = model_mix(in_state[i], in_inv[i]);
                    pend[i]    = 1'b1;
                    acc_cyc[i] = cyc;
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst && out_valid[i]) begin
                if (!pend[i]) begin
                    n_cmp++;
                    n_bad++;
                    $display("[TB] FAIL spurious_out_valid[%0d]: got out_valid=1 expected 0", i);
                end else begin
                    check_output($sformatf("result[%0d]", i), out_state[i], exp_r[i]);
                    if (!prev_ov[i])
                        check_output($sformatf("latency[%0d]", i), 128'(cyc - acc_cyc[i] - 1), 128'(4 >> i));
                end
            end
            prev_ov[i] = out_valid[i] && !rst;
        end
    end

    task automatic apply_stimulus(input int d, input logic [127:0] s, input logic inv,
                                  input int stall, output logic [127:0] res);
        int t;
        res = '0;
        t = 0;
        while (!in_ready[d] && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready[d]) begin
            timeout_fail("in_ready_wait");
            return;
        end
        out_ready[d] = (stall == 0);
        in_valid[d]  = 1'b1;
        in_state[d]  = s;
        in_inv[d]    = inv;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        in_state[d] = {$urandom, $urandom, $urandom, $urandom};
        in_inv[d]   = ~inv;
        t = 0;
        while (!out_valid[d] && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!out_valid[d]) begin
            timeout_fail("out_valid_wait");
            out_ready[d] = 1'b1;
            return;
        end
        res = out_state[d];
        if (stall > 0) begin
            in_valid[d] = 1'b1;
            for (int k = 0; k < stall; k++) begin
                @(posedge clk); #1;
                check_output("stall_in_ready", 128'(in_ready[d]), 128'(0));
                check_output("stall_out_valid", 128'(out_valid[d]), 128'(1));
            end
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
        end
        @(posedge clk); #1;
        check_output("out_valid_fall", 128'(out_valid[d]), 128'(0));
        check_output("in_ready_return", 128'(in_ready[d]), 128'(1));
        in_inv[d] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [127:0] x, y, z;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            in_inv[i]    = 1'b0;
            in_state[i]  = '0;
            out_ready[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_output("reset_in_ready", 128'(in_ready[i]), 128'(1));
            check_output("reset_out_valid", 128'(out_valid[i]), 128'(0));
            check_output("reset_busy", 128'(busy[i]), 128'(0));
            check_output("reset_out_state", out_state[i], 128'(0));
        end
        rst = 1'b0;
        @(posedge clk); #1;

        check_output("model_gf_57x83", 128'(gf_mult(8'h57, 8'h83)), 128'(8'hc1));
        check_output("model_fwd_vec", model_mix(VEC_IN, 1'b0), VEC_FWD);
        check_output("model_inv_vec", model_mix(VEC_FWD, 1'b1), VEC_IN);

        for (int d = 0; d < 3; d++) begin
            apply_stimulus(d, VEC_IN, 1'b0, 0, y);
            check_output("directed_fwd", y, VEC_FWD);
            apply_stimulus(d, VEC_FWD, 1'b1, 0, y);
            check_output("directed_inv", y, VEC_IN);
        end

        apply_stimulus(0, VEC_IN, 1'b0, 10, y);
        check_output("backpressure_fwd", y, VEC_FWD);

        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_state[0]  = VEC_IN;
        in_inv[0]    = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_output("midrun_rst_out_valid", 128'(out_valid[0]), 128'(0));
        check_output("midrun_rst_out_state", out_state[0], 128'(0));
        check_output("midrun_rst_in_ready", 128'(in_ready[0]), 128'(1));
        check_output("midrun_rst_busy", 128'(busy[0]), 128'(0));
        @(posedge clk); #2;
        rst = 1'b0;
        apply_stimulus(0, VEC_IN, 1'b0, 0, y);
        check_output("after_rst_fwd", y, VEC_FWD);

        for (int n = 0; n < 60; n++) begin
            int d;
            d = int'($urandom_range(0, 2));
            x = {$urandom, $urandom, $urandom, $urandom};
            apply_stimulus(d, x, 1'b0, int'($urandom_range(0, 3)), y);
            apply_stimulus(d, y, 1'b1, int'($urandom_range(0, 3)), z);
            check_output("roundtrip", z, x);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
